// File: rtl/lcd_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_timing_gen_if
//  Purpose  : Bundle of control inputs and timing outputs exchanged between
//             the LCD scan timing generator and the CPU / memory-mapped I/O side.
//  Modports : master - CPU / I/O side: drives ce, lcd_en, ly_clr, lyc,
//                      stat_sel; observes ly, mode, coincidence and the pulses
//             slave  - timing generator: the mirror image of master
//  Revision : 1.0 - initial release
// ============================================================================
interface lcd_timing_gen_if;
    logic       ce;           // dot enable
    logic       lcd_en;       // LCDC bit 7
    logic       ly_clr;       // CPU write strobe to LY
    logic [7:0] lyc;          // LYC register (FF45)
    logic [3:0] stat_sel;     // {lyc, mode2, mode1, mode0} interrupt selects
    logic [7:0] ly;           // current line (FF44)
    logic [1:0] mode;         // FF41[1:0]
    logic       coincidence;  // FF41[2]
    logic       vblank_irq;   // one-cycle pulse at VBlank entry
    logic       stat_irq;     // one-cycle pulse on STAT line rising edge
    logic       frame_start;  // one-cycle pulse on entering ly=0, dot=0

    modport master (
        output ce, lcd_en, ly_clr, lyc, stat_sel,
        input  ly, mode, coincidence, vblank_irq, stat_irq, frame_start
    );

    modport slave (
        input  ce, lcd_en, ly_clr, lyc, stat_sel,
        output ly, mode, coincidence, vblank_irq, stat_irq, frame_start
    );
endinterface : lcd_timing_gen_if
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_timing_gen
//  Purpose  : LCD scan timing generator. Dot counter, LY line counter, STAT
//             mode, LYC coincidence, VBlank and STAT interrupt pulses.
//  Ports    : clk_i  - system clock
//             rst_i  - synchronous active-high reset
//             bus    - lcd_timing_gen_if.slave (ce, lcd_en, ly_clr, lyc,
//                      stat_sel in; ly, mode, coincidence, vblank_irq,
//                      stat_irq, frame_start out)
//  Options  : LCD_FAST_VBLANK_EN - when defined, LY wraps from the last line
//             to FAST_WRAP_LINE with no frame_start (simulation speed-up only,
//             never defined for synthesis).
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int DOTS_PER_LINE  = 456,
    parameter int OAM_DOTS       = 80,
    parameter int XFER_DOTS      = 172,
    parameter int VISIBLE_LINES  = 144,
    parameter int TOTAL_LINES    = 154,
    parameter int DOT_W          = 9,
    parameter int FAST_WRAP_LINE = 140
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    lcd_timing_gen_if.slave    bus
);

    localparam logic [1:0] c_MODE_HBLANK = 2'd0;
    localparam logic [1:0] c_MODE_VBLANK = 2'd1;
    localparam logic [1:0] c_MODE_OAM    = 2'd2;
    localparam logic [1:0] c_MODE_XFER   = 2'd3;

    localparam logic [DOT_W-1:0] c_dot_last = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] c_oam_end  = DOT_W'(OAM_DOTS);
    localparam logic [DOT_W-1:0] c_xfer_end = DOT_W'(OAM_DOTS + XFER_DOTS);
    localparam logic [DOT_W-1:0] c_dot_one  = DOT_W'(1);
    localparam logic [7:0]       c_ly_last  = 8'(TOTAL_LINES - 1);
    localparam logic [7:0]       c_ly_vis   = 8'(VISIBLE_LINES);

`ifdef LCD_FAST_VBLANK_EN
    localparam bit c_fast_wrap = 1'b1;
`else
    localparam bit c_fast_wrap = 1'b0;
`endif
    // Line reached after the last line of the frame.
    localparam logic [7:0] c_ly_wrap = c_fast_wrap ? 8'(FAST_WRAP_LINE) : 8'd0;

    logic             on_q,          on_d;
    logic [DOT_W-1:0] dot_q,         dot_d;
    logic [7:0]       ly_q,          ly_d;
    logic [1:0]       mode_q,        mode_d;
    logic             coin_q,        coin_d;
    logic             vblank_q,      vblank_d;
    logic             stat_irq_q,    stat_irq_d;
    logic             frame_start_q, frame_start_d;
    logic             stat_line_q,   stat_line_d;

    // Set on cycles that move the timing state (enable, clear, dot advance);
    // only those may produce a STAT edge.
    logic             w_upd;
    logic             w_stat_line;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            on_q          <= 1'b0;
            dot_q         <= '0;
            ly_q          <= '0;
            mode_q        <= c_MODE_HBLANK;
            coin_q        <= 1'b0;
            vblank_q      <= 1'b0;
            stat_irq_q    <= 1'b0;
            frame_start_q <= 1'b0;
            stat_line_q   <= 1'b0;
        end else begin
            on_q          <= on_d;
            dot_q         <= dot_d;
            ly_q          <= ly_d;
            mode_q        <= mode_d;
            coin_q        <= coin_d;
            vblank_q      <= vblank_d;
            stat_irq_q    <= stat_irq_d;
            frame_start_q <= frame_start_d;
            stat_line_q   <= stat_line_d;
        end
    end

    // ------------------------------------------------------------------
    // Counter next state: off > clear/enable restart > dot advance
    // ------------------------------------------------------------------
    always_comb begin
        on_d          = bus.lcd_en;
        dot_d         = dot_q;
        ly_d          = ly_q;
        frame_start_d = 1'b0;
        vblank_d      = 1'b0;
        w_upd         = 1'b0;
        if (!bus.lcd_en) begin
            dot_d = '0;
            ly_d  = '0;
        end else if (!on_q || bus.ly_clr) begin
            // First enabled cycle or LY write: restart the frame, no dot step.
            dot_d         = '0;
            ly_d          = '0;
            frame_start_d = 1'b1;
            w_upd         = 1'b1;
        end else if (bus.ce) begin
            w_upd = 1'b1;
            if (dot_q == c_dot_last) begin
                dot_d = '0;
                if (ly_q == c_ly_last) begin
                    ly_d          = c_ly_wrap;
                    frame_start_d = ~c_fast_wrap;
                end else begin
                    ly_d = ly_q + 8'd1;
                end
                vblank_d = (ly_d == c_ly_vis);
            end else begin
                dot_d = dot_q + c_dot_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mode, coincidence and STAT line, all from the next-state counters so
    // the registered outputs line up with dot/ly.
    // ------------------------------------------------------------------
    always_comb begin
        if (!bus.lcd_en)              mode_d = c_MODE_HBLANK;
        else if (ly_d >= c_ly_vis)    mode_d = c_MODE_VBLANK;
        else if (dot_d < c_oam_end)   mode_d = c_MODE_OAM;
        else if (dot_d < c_xfer_end)  mode_d = c_MODE_XFER;
        else                          mode_d = c_MODE_HBLANK;

        coin_d = (ly_d == bus.lyc);

        w_stat_line = (bus.stat_sel[0] && (mode_d == c_MODE_HBLANK)) ||
                      (bus.stat_sel[1] && (mode_d == c_MODE_VBLANK)) ||
                      (bus.stat_sel[2] && (mode_d == c_MODE_OAM))    ||
                      (bus.stat_sel[3] && coin_d);

        if (!bus.lcd_en) begin
            stat_line_d = 1'b0;
            stat_irq_d  = 1'b0;
        end else if (w_upd) begin
            // Only a rising edge interrupts; a source taking over while the
            // line is already high is blocked.
            stat_line_d = w_stat_line;
            stat_irq_d  = w_stat_line & ~stat_line_q;
        end else begin
            stat_line_d = stat_line_q;
            stat_irq_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ly          = ly_q;
    assign bus.mode        = mode_q;
    assign bus.coincidence = coin_q;
    assign bus.vblank_irq  = vblank_q;
    assign bus.stat_irq    = stat_irq_q;
    assign bus.frame_start = frame_start_q;

endmodule : lcd_timing_gen
`default_nettype wire
